fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the address and instruction width.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-003 The block SHALL have one clock and one reset; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-low reset.
REQ-006 imem_addr  output  XLEN  byte address to instruction memory read port; combinational copy of pc.
REQ-007 imem_data  input  XLEN  instruction returned combinationally for imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump redirect request.
REQ-009 redirect_pc  input  XLEN  redirect target.
REQ-010 id_ready  input  1  decode accepts head entry this cycle.
REQ-011 id_valid  output  1  head entry valid.
REQ-012 id_pc  output  XLEN  PC of head entry.
REQ-013 id_instr  output  XLEN  instruction of head entry.
REQ-014 fetch_misaligned  output  1  sticky misaligned-target flag.

Function
REQ-015 Internal state SHALL be pc (XLEN), a 2-entry queue of {pc, instr} with count 0..2, and an FSM with states RUN and HALT.
REQ-016 id_valid SHALL equal (count != 0); id_pc/id_instr SHALL be the registered head entry, with no combinational path from imem_data.
REQ-017 pop SHALL occur when id_valid && id_ready; push SHALL occur when state==RUN, no redirect, and (count<2 || pop).
REQ-018 On push: {pc, imem_data} SHALL be written at the tail, and pc SHALL advance to pc+4 modulo 2^XLEN (0xFFFF_FFFC wraps to 0).
REQ-019 Simultaneous push and pop at count==2 SHALL leave count 2 and preserve order; at count==1 it SHALL leave count 1.
REQ-020 Pop at count==0 SHALL be ignored; push at count==2 without pop SHALL NOT occur.
REQ-021 Redirect SHALL have priority over push and pop.
REQ-022 On redirect: queue flushed (count=0), pc<=redirect_pc, no push that cycle.
REQ-023 Redirect timing: redirect in cycle n -> id_valid=0 in n+1 -> head pc=redirect_pc with id_valid=1 in n+2.
REQ-024 A redirect in cycle n+1 SHALL override the one in cycle n with no intervening push.
REQ-025 Steady-state throughput with id_ready held high SHALL be one instruction per cycle.

Reset
REQ-026 While rst==0: pc=RESET_PC, count=0, state=RUN, fetch_misaligned=0, id_valid=0, id_pc=0, id_instr=0.
REQ-027 Reset SHALL override redirect and handshakes in the same cycle; reset mid-stream SHALL discard queued entries.
REQ-028 The first push SHALL occur in the first cycle with rst==1, giving id_valid=1 with id_pc=RESET_PC one cycle later.

Configuration
REQ-029 Macro FETCH_MISALIGN_TRAP_EN SHALL select misaligned-target handling.
REQ-030 With FETCH_MISALIGN_TRAP_EN defined: a redirect with redirect_pc[1:0]!=0 SHALL flush the queue, enter HALT, and set fetch_misaligned=1 from the next cycle.
REQ-031 In HALT: no pushes, imem_addr holds the faulting target, and fetch_misaligned stays 1.
REQ-032 HALT SHALL exit to RUN only on an aligned redirect, which clears the flag next cycle, or on reset.
REQ-033 Without FETCH_MISALIGN_TRAP_EN: redirect_pc[1:0] SHALL be forced to 00, HALT SHALL be unreachable, and fetch_misaligned SHALL be constant 0.

Structure
REQ-034 Shared package if_pkg SHALL hold XLEN, RESET_PC default, the PC increment constant (4), the FSM state encoding, and the queue entry width (2*XLEN).
REQ-035 The 2-entry queue SHALL be sub-module fetch_queue (push/pop/flush, count, head outputs); pc and FSM SHALL stay in fetch_unit.

Verification
REQ-036 Reset release with id_ready=1 and a memory model returning 0x00000013 at every address -> id_pc = 0x0, 0x4, 0x8, ... on consecutive cycles, with id_valid continuously 1 from the cycle after release.
REQ-037 id_ready=0 for 5 cycles -> count saturates at 2, imem_addr stops at 0x8, id_pc holds 0x0; id_ready=1 -> 0x0, 0x4, 0x8 delivered without gap or duplicate.
REQ-038 Redirect to 0x100 with count==2 and id_ready=1 in the same cycle -> id_valid=0 next cycle, then id_pc=0x100, then 0x104.
REQ-039 Redirect to 0xFFFF_FFFC -> id_pc sequence 0xFFFF_FFFC, 0x0000_0000.
REQ-040 With macro defined: redirect to 0x102 -> fetch_misaligned=1, id_valid=0, and no pushes for 10 cycles; then redirect to 0x200 -> flag clears and id_pc=0x200. Without macro: redirect to 0x102 -> id_pc=0x100.
REQ-041 rst=0 asserted for one cycle mid-stream with count==2 -> id_valid=0 during reset; id_pc=RESET_PC two cycles after the reset cycle.

Source files
------------

// File: rtl/if_pkg.sv
// Shared fetch-stage constants: default widths, reset PC, PC increment,
// FSM state encoding and queue entry width.
package if_pkg;

  localparam int unsigned XLEN             = 32;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_INC           = 4;
  localparam int unsigned ENTRY_W          = 2 * XLEN;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_HALT = 1'b1;

endpackage

// File: rtl/fetch_queue.sv
// Two-entry in-order queue of {pc, instr}; slot0 is always the registered head.
module fetch_queue
  import if_pkg::*;
#(
  parameter int unsigned W = ENTRY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [1:0]   count,
  output logic [W-1:0] head
);

  logic [W-1:0] slot0;
  logic [W-1:0] slot1;
  logic         do_pop;
  logic         do_push;

  // Pop on empty is dropped; push into a full queue only when a pop frees a slot.
  always_comb begin
    do_pop  = pop && (count != 2'd0);
    do_push = push && ((count != 2'd2) || do_pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= '0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_data;
          else               slot1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            slot0 <= push_data;
          end else begin
            slot0 <= slot1;
            slot1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, RUN/HALT control and a 2-entry fetch queue.
// FETCH_MISALIGN_TRAP_EN enables halting on misaligned redirect targets.
module fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned     XLEN     = if_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_ready,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [XLEN-1:0] id_instr,
  output logic            fetch_misaligned
);

  logic [XLEN-1:0]   pc;
  logic [0:0]        state;
  logic [XLEN-1:0]   target;
  logic              bad_target;
  logic              pop;
  logic              push;
  logic [1:0]        count;
  logic [2*XLEN-1:0] head;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic trap_flag;

  assign target     = redirect_pc;
  assign bad_target = redirect_valid && (redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rst)                trap_flag <= 1'b0;
    else if (redirect_valid) trap_flag <= bad_target;
  end

  assign fetch_misaligned = trap_flag;
`else
  logic unused_target_lsbs;

  assign target             = {redirect_pc[XLEN-1:2], 2'b00};
  assign bad_target         = 1'b0;
  assign unused_target_lsbs = ^redirect_pc[1:0];
  assign fetch_misaligned   = 1'b0;
`endif

  assign pop  = id_valid && id_ready;
  assign push = (state == ST_RUN) && !redirect_valid && ((count != 2'd2) || pop);

  // A redirect always wins: it retargets pc and picks the next state, never pushes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc    <= RESET_PC;
      state <= ST_RUN;
    end else if (redirect_valid) begin
      pc    <= target;
      state <= bad_target ? ST_HALT : ST_RUN;
    end else if (push) begin
      pc <= pc + XLEN'(PC_INC);
    end
  end

  fetch_queue #(
    .W (2 * XLEN)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect_valid),
    .push      (push),
    .pop       (pop),
    .push_data ({pc, imem_data}),
    .count     (count),
    .head      (head)
  );

  assign imem_addr = pc;
  assign id_valid  = (count != 2'd0);
  assign id_pc     = head[2*XLEN-1:XLEN];
  assign id_instr  = head[XLEN-1:0];

endmodule
